codec_stream_ctrl: RTL and testbench
====================================

Name: codec_stream_ctrl

Overview:
Sequencer and arbiter for the audio_codec read/write handshake. It pulls stereo sample pairs from the codec ADC path into a small FIFO and pushes them back to the DAC path (loopback). It also presents each captured left sample, with a one-cycle valid strobe, to the signal-analysis logic. It replaces the constant read/write tie-offs at the top level.

Parameters:
DATA_W, 24, width of one channel sample
DEPTH, 8, FIFO depth in stereo pairs; power of two, >= 2
CNT_W, 4, width of fill_level (must hold 0..DEPTH, i.e. log2(DEPTH)+1)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = accept new ADC samples; 0 = stop reading, keep draining to DAC
mute  in  1  1 = DAC receives zeros; FIFO still pops
clear_flags  in  1  synchronous clear of sticky overrun/underrun
read_ready  in  1  codec has an ADC pair available
write_ready  in  1  codec can accept a DAC pair
readdata_left  in  DATA_W  codec ADC left
readdata_right  in  DATA_W  codec ADC right
read  out  1  one-cycle pop strobe to codec
write  out  1  one-cycle push strobe to codec
writedata_left  out  DATA_W  DAC left, registered
writedata_right  out  DATA_W  DAC right, registered
sample_valid  out  1  one-cycle strobe: new ADC pair captured
sample_left  out  DATA_W  captured left sample, held until next capture
fill_level  out  CNT_W  current FIFO occupancy, 0..DEPTH
overrun  out  1  sticky: codec had data while FIFO full
underrun  out  1  sticky: codec wanted data while FIFO empty

Behaviour:
- Reset:
  - All outputs are 0, FIFO is empty, FSM is in IDLE, rr_last_rd=0.
  - Reset has priority over every other input and aborts any state.
- FSM states: IDLE, RD, WR, GAP. Exactly one codec transfer per RD or WR visit.
- IDLE evaluates:
  - rd_ok = enable & read_ready & !full
  - wr_ok = write_ready & !empty
- IDLE transitions:
  - Only rd_ok -> RD.
  - Only wr_ok -> WR.
  - Both -> round-robin: RD if rr_last_rd==0, else WR.
  - Neither -> stay in IDLE.
- RD (1 cycle):
  - read=1.
  - readdata_left/right are pushed into the FIFO as {left,right}.
  - sample_left <= readdata_left; sample_valid=1 in this same cycle.
  - rr_last_rd <= 1.
  - -> GAP.
- WR entry (IDLE->WR edge):
  - writedata_* <= FIFO head, or 0 if mute.
  - FIFO pops on this edge.
- WR (1 cycle):
  - write=1, writedata stable.
  - rr_last_rd <= 0.
  - -> GAP.
- writedata_* hold their value outside WR.
- GAP (1 cycle): read=write=0; lets the codec ready flags update. -> IDLE.
- Transfer rate: minimum 3 cycles per transfer, i.e. read and write strobes never closer than 3 cycles apart. At 50 MHz this is far above the 48 kHz x 2 demand.
- FIFO push and pop never occur in the same cycle, by construction of the FSM.
- fill_level:
  - +1 on the RD cycle, -1 on the WR-entry pop.
  - full = (fill_level==DEPTH), empty = (fill_level==0).
  - Pointers wrap modulo DEPTH.
- overrun: set in IDLE when enable & read_ready & full.
- underrun: set in IDLE when enable & write_ready & empty.
- Flag clearing: clear_flags clears both flags. If a set condition and clear_flags occur in the same cycle, set wins.
- enable falling mid-RD: the RD still completes. No new reads start after that; the FIFO keeps draining via WR.
- mute affects only the data loaded on WR entry. Toggling mute during WR does not change the current writedata.

Decomposition:
- Package codec_pkg:
  - DATA_W default
  - FSM state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2, GAP=2'd3)
  - stereo pair width (2*DATA_W)
- Sub-module sample_fifo:
  - Synchronous single-clock FIFO, width 2*DATA_W, depth DEPTH.
  - Ports: push, pop, din, dout (show-ahead head), full, empty, count.
  - Synchronous active-high reset.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then read_ready=write_ready=0.
  - Response: read=write=0, fill_level=0, writedata_*=0, flags=0 for 10 cycles.
- Single loopback:
  - Stimulus: read_ready=1 with readdata_left=24'h123456, readdata_right=24'hABCDEF; drop read_ready after the read pulse; then write_ready=1.
  - Response: read high exactly 1 cycle; sample_valid with sample_left=24'h123456; fill_level 0->1->0; write high 1 cycle with writedata=24'h123456 / 24'hABCDEF.
- Round-robin:
  - Stimulus: FIFO holds 2 pairs; read_ready and write_ready both held at 1.
  - Response: strobe order RD, WR, RD, WR, each separated by 3 cycles; fill_level alternates 3, 2, 3, 2.
- Full/overrun:
  - Stimulus: write_ready=0, read_ready=1 for more than 8 reads.
  - Response: exactly 8 read pulses, fill_level=8, overrun=1. After clear_flags with read_ready=0, overrun=0.
- Mute and underrun:
  - Stimulus: mute=1 with 1 pair queued, write_ready=1.
  - Response: write pulse with writedata=0, fill_level=0. One more IDLE cycle with write_ready=1 sets underrun=1.
- Reset mid-operation:
  - Stimulus: assert reset during the RD cycle with FIFO holding 3 pairs.
  - Response: next cycle fill_level=0, read=0, FSM in IDLE, sample_valid=0.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared definitions for the codec loopback streaming controller.
package codec_pkg;

   localparam int DATA_W_DEF = 24;
   localparam int PAIR_W_DEF = 2 * DATA_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO of stereo pairs with show-ahead head and occupancy count.
module sample_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Guarded so a misbehaving caller can never corrupt the occupancy.
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign dout  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/codec_stream_ctrl.sv
// Codec read/write sequencer: ADC pairs into a FIFO, looped back to the DAC,
// with round-robin arbitration when both directions are ready.
module codec_stream_ctrl
   import codec_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              enable,
   input  logic              mute,
   input  logic              clear_flags,
   input  logic              read_ready,
   input  logic              write_ready,
   input  logic [DATA_W-1:0] readdata_left,
   input  logic [DATA_W-1:0] readdata_right,
   output logic              read,
   output logic              write,
   output logic [DATA_W-1:0] writedata_left,
   output logic [DATA_W-1:0] writedata_right,
   output logic              sample_valid,
   output logic [DATA_W-1:0] sample_left,
   output logic [CNT_W-1:0]  fill_level,
   output logic              overrun,
   output logic              underrun
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rr_last_rd;
   logic [DATA_W-1:0]   r_wd_left;
   logic [DATA_W-1:0]   r_wd_right;
   logic [DATA_W-1:0]   r_sample_left;
   logic                r_overrun;
   logic                r_underrun;
   logic                w_full;
   logic                w_empty;
   logic                w_rd_ok;
   logic                w_wr_ok;
   logic                w_push;
   logic                w_pop;
   logic                w_ov_set;
   logic                w_un_set;
   logic [2*DATA_W-1:0] w_head;
   logic [CNT_W-1:0]    w_count;

   assign w_rd_ok  = enable & read_ready & ~w_full;
   assign w_wr_ok  = write_ready & ~w_empty;
   assign w_ov_set = (r_state == ST_IDLE) & enable & read_ready & w_full;
   assign w_un_set = (r_state == ST_IDLE) & enable & write_ready & w_empty;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_rd_ok && (!w_wr_ok || !r_rr_last_rd)) w_state_nxt = ST_RD;
            else if (w_wr_ok)                           w_state_nxt = ST_WR;
         end
         ST_RD:  w_state_nxt = ST_GAP;
         ST_WR:  w_state_nxt = ST_GAP;
         ST_GAP: w_state_nxt = ST_IDLE;
      endcase
   end

   // Pop on the IDLE->WR edge so the head is already in writedata during WR.
   assign w_push = (r_state == ST_RD);
   assign w_pop  = (r_state == ST_IDLE) && (w_state_nxt == ST_WR);

   sample_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (CLOCK_50),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({readdata_left, readdata_right}),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_rr_last_rd  <= 1'b0;
         r_wd_left     <= '0;
         r_wd_right    <= '0;
         r_sample_left <= '0;
         r_overrun     <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_RD) begin
            r_rr_last_rd  <= 1'b1;
            r_sample_left <= readdata_left;
         end
         if (r_state == ST_WR) r_rr_last_rd <= 1'b0;
         if (w_pop) begin
            r_wd_left  <= mute ? '0 : w_head[2*DATA_W-1:DATA_W];
            r_wd_right <= mute ? '0 : w_head[DATA_W-1:0];
         end
         // A set in the same cycle as a clear takes precedence.
         r_overrun  <= w_ov_set | (r_overrun & ~clear_flags);
         r_underrun <= w_un_set | (r_underrun & ~clear_flags);
      end
   end

   assign read            = (r_state == ST_RD);
   assign write           = (r_state == ST_WR);
   assign sample_valid    = (r_state == ST_RD);
   assign writedata_left  = r_wd_left;
   assign writedata_right = r_wd_right;
   assign sample_left     = r_sample_left;
   assign fill_level      = w_count;
   assign overrun         = r_overrun;
   assign underrun        = r_underrun;

endmodule

// File: tb/tb_codec_stream_ctrl.sv
// Self-checking bench for codec_stream_ctrl: directed scenarios plus a
// randomized run scored against a queue-based loopback model.
module tb_codec_stream_ctrl;

   localparam int DW    = 24;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic          CLOCK_50 = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          mute = 1'b0;
   logic          clear_flags = 1'b0;
   logic          read_ready = 1'b0;
   logic          write_ready = 1'b0;
   logic [DW-1:0] readdata_left = '0;
   logic [DW-1:0] readdata_right = '0;
   logic          read;
   logic          write;
   logic [DW-1:0] writedata_left;
   logic [DW-1:0] writedata_right;
   logic          sample_valid;
   logic [DW-1:0] sample_left;
   logic [CW-1:0] fill_level;
   logic          overrun;
   logic          underrun;

   int n_pass  = 0;
   int n_total = 0;

   codec_stream_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .enable          (enable),
      .mute            (mute),
      .clear_flags     (clear_flags),
      .read_ready      (read_ready),
      .write_ready     (write_ready),
      .readdata_left   (readdata_left),
      .readdata_right  (readdata_right),
      .read            (read),
      .write           (write),
      .writedata_left  (writedata_left),
      .writedata_right (writedata_right),
      .sample_valid    (sample_valid),
      .sample_left     (sample_left),
      .fill_level      (fill_level),
      .overrun         (overrun),
      .underrun        (underrun)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge CLOCK_50);
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; mute = 1'b0; clear_flags = 1'b0;
      read_ready = 1'b0; write_ready = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   // which: 0 = read strobe, 1 = write strobe, 2 = fill_level reaches target
   task automatic wait_sig(input int which, input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if ((which == 0 && read) || (which == 1 && write) ||
             (which == 2 && int'(fill_level) == target)) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step();
         n_total++;
         if ({read, write, fill_level, writedata_left, writedata_right,
              overrun, underrun, sample_valid, sample_left} !== '0)
            $display("FAIL reset_idle cyc%0d: rd=%b wr=%b fill=%0d wdl=%h wdr=%h ov=%b un=%b sv=%b sl=%h, expected all 0",
                     i, read, write, fill_level, writedata_left, writedata_right,
                     overrun, underrun, sample_valid, sample_left);
         else n_pass++;
      end
   endtask

   task automatic test_loopback();
      bit ok;
      enable = 1'b1;
      readdata_left = 24'h123456; readdata_right = 24'hABCDEF;
      read_ready = 1'b1;
      wait_sig(0, 1, 10, ok);
      n_total++; if (!ok) $display("FAIL loop_read_seen: got none, expected read pulse"); else n_pass++;
      n_total++; if (sample_valid !== 1'b1) $display("FAIL loop_sample_valid: got %b expected 1", sample_valid); else n_pass++;
      n_total++; if (fill_level !== 4'd0) $display("FAIL loop_fill_rd: got %0d expected 0", fill_level); else n_pass++;
      read_ready = 1'b0;
      step();
      n_total++; if (read !== 1'b0) $display("FAIL loop_read_width: got %b expected 0", read); else n_pass++;
      n_total++; if (fill_level !== 4'd1) $display("FAIL loop_fill_1: got %0d expected 1", fill_level); else n_pass++;
      n_total++; if (sample_left !== 24'h123456) $display("FAIL loop_sample_left: got %h expected 123456", sample_left); else n_pass++;
      write_ready = 1'b1;
      wait_sig(1, 1, 10, ok);
      n_total++; if (!ok) $display("FAIL loop_write_seen: got none, expected write pulse"); else n_pass++;
      n_total++;
      if ({writedata_left, writedata_right} !== 48'h123456ABCDEF)
         $display("FAIL loop_writedata: got %h/%h expected 123456/abcdef", writedata_left, writedata_right);
      else n_pass++;
      n_total++; if (fill_level !== 4'd0) $display("FAIL loop_fill_0: got %0d expected 0", fill_level); else n_pass++;
      write_ready = 1'b0;
      step();
      n_total++; if (write !== 1'b0) $display("FAIL loop_write_width: got %b expected 0", write); else n_pass++;
      n_total++; if (underrun !== 1'b0) $display("FAIL loop_underrun: got %b expected 0", underrun); else n_pass++;
   endtask

   task automatic test_round_robin();
      bit ok;
      int kind [4];
      int tcyc [4];
      int fl   [4];
      int ns = 0;
      bit want_fill = 1'b0;
      int exp_fl;
      // Three reads then one write leaves two pairs with the write served last.
      do_reset();
      enable = 1'b1;
      read_ready = 1'b1;
      wait_sig(2, 3, 40, ok);
      read_ready = 1'b0;
      n_total++; if (!ok) $display("FAIL rr_prefill: fill=%0d expected 3", fill_level); else n_pass++;
      write_ready = 1'b1;
      wait_sig(1, 1, 20, ok);
      write_ready = 1'b0;
      n_total++; if (fill_level !== 4'd2) $display("FAIL rr_start_fill: got %0d expected 2", fill_level); else n_pass++;
      read_ready = 1'b1; write_ready = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (want_fill) begin fl[ns-1] = int'(fill_level); want_fill = 1'b0; end
         if (ns < 4 && (read || write)) begin
            kind[ns] = read ? 0 : 1;
            tcyc[ns] = c;
            ns++;
            want_fill = 1'b1;
         end
      end
      read_ready = 1'b0; write_ready = 1'b0;
      n_total++; if (ns != 4) $display("FAIL rr_count: got %0d strobes expected 4", ns); else n_pass++;
      for (int i = 0; i < ns; i++) begin
         exp_fl = (i % 2 == 0) ? 3 : 2;
         n_total++;
         if (kind[i] != i % 2) $display("FAIL rr_order%0d: got %s expected %s", i,
                                       kind[i] == 0 ? "RD" : "WR", (i % 2 == 0) ? "RD" : "WR");
         else n_pass++;
         n_total++;
         if (fl[i] != exp_fl) $display("FAIL rr_fill%0d: got %0d expected %0d", i, fl[i], exp_fl);
         else n_pass++;
         if (i > 0) begin
            n_total++;
            if (tcyc[i] - tcyc[i-1] != 3)
               $display("FAIL rr_spacing%0d: got %0d expected 3", i, tcyc[i] - tcyc[i-1]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_full_overrun();
      int nr = 0;
      do_reset();
      enable = 1'b1; read_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (read) nr++;
      end
      n_total++; if (nr != DEPTH) $display("FAIL full_reads: got %0d expected %0d", nr, DEPTH); else n_pass++;
      n_total++; if (fill_level !== 4'd8) $display("FAIL full_fill: got %0d expected 8", fill_level); else n_pass++;
      n_total++; if (overrun !== 1'b1) $display("FAIL full_overrun: got %b expected 1", overrun); else n_pass++;
      n_total++; if (underrun !== 1'b0) $display("FAIL full_underrun: got %b expected 0", underrun); else n_pass++;
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      n_total++; if (overrun !== 1'b1) $display("FAIL ov_set_wins: got %b expected 1", overrun); else n_pass++;
      read_ready = 1'b0; clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      step();
      n_total++; if (overrun !== 1'b0) $display("FAIL ov_clear: got %b expected 0", overrun); else n_pass++;
   endtask

   task automatic test_mute_underrun();
      bit ok;
      do_reset();
      enable = 1'b1;
      readdata_left = DW'($urandom) | 24'h000001; readdata_right = DW'($urandom) | 24'h000001;
      read_ready = 1'b1;
      wait_sig(0, 1, 10, ok);
      read_ready = 1'b0;
      step();
      mute = 1'b1; write_ready = 1'b1;
      wait_sig(1, 1, 10, ok);
      n_total++; if (!ok) $display("FAIL mute_write_seen: got none, expected write pulse"); else n_pass++;
      n_total++;
      if ({writedata_left, writedata_right} !== 48'h0)
         $display("FAIL mute_data: got %h/%h expected 0/0", writedata_left, writedata_right);
      else n_pass++;
      n_total++; if (fill_level !== 4'd0) $display("FAIL mute_fill: got %0d expected 0", fill_level); else n_pass++;
      mute = 1'b0;
      step();
      n_total++;
      if ({writedata_left, writedata_right} !== 48'h0)
         $display("FAIL mute_hold: got %h/%h expected 0/0", writedata_left, writedata_right);
      else n_pass++;
      step();
      n_total++; if (underrun !== 1'b0) $display("FAIL un_early: got %b expected 0", underrun); else n_pass++;
      step();
      n_total++; if (underrun !== 1'b1) $display("FAIL un_set: got %b expected 1", underrun); else n_pass++;
      write_ready = 1'b0; clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      n_total++; if (underrun !== 1'b0) $display("FAIL un_clear: got %b expected 0", underrun); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      enable = 1'b1; read_ready = 1'b1;
      wait_sig(2, 3, 40, ok);
      read_ready = 1'b0;
      step(); step();
      read_ready = 1'b1;
      wait_sig(0, 1, 10, ok);
      n_total++; if (!ok) $display("FAIL rmid_read_seen: got none, expected read pulse"); else n_pass++;
      reset = 1'b1;
      step();
      n_total++;
      if ({fill_level, read, write, sample_valid} !== '0)
         $display("FAIL rmid_state: fill=%0d rd=%b wr=%b sv=%b expected all 0", fill_level, read, write, sample_valid);
      else n_pass++;
      reset = 1'b0; read_ready = 1'b0;
      step();
      n_total++; if (fill_level !== 4'd0) $display("FAIL rmid_after: fill=%0d expected 0", fill_level); else n_pass++;
   endtask

   task automatic test_random();
      logic [2*DW-1:0] q[$];
      logic [2*DW-1:0] exp_pair;
      logic [DW-1:0]   exp_left = '0;
      int              last_strobe = -100;
      bit              prev_read = 1'b0;
      bit              fill_phase;
      int              fill_errs = 0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         if (prev_read) begin
            n_total++;
            if (sample_left !== exp_left) $display("FAIL rnd_sample_left cyc%0d: got %h expected %h", cyc, sample_left, exp_left);
            else n_pass++;
         end
         if (write) begin
            n_total++;
            if (q.size() == 0) $display("FAIL rnd_write_empty cyc%0d: write with model empty", cyc);
            else begin
               n_pass++;
               exp_pair = q.pop_front();
               n_total++;
               if ({writedata_left, writedata_right} !== exp_pair)
                  $display("FAIL rnd_writedata cyc%0d: got %h%h expected %h", cyc, writedata_left, writedata_right, exp_pair);
               else n_pass++;
            end
         end
         if (read) begin
            n_total++;
            if (q.size() >= DEPTH) $display("FAIL rnd_read_full cyc%0d: read with model size %0d", cyc, q.size());
            else n_pass++;
         end
         if (read || write) begin
            n_total++;
            if (cyc - last_strobe < 3) $display("FAIL rnd_spacing cyc%0d: got %0d expected >=3", cyc, cyc - last_strobe);
            else n_pass++;
            last_strobe = cyc;
         end
         n_total++;
         if (int'(fill_level) !== q.size()) begin
            if (fill_errs < 10) $display("FAIL rnd_fill cyc%0d: got %0d expected %0d", cyc, fill_level, q.size());
            fill_errs++;
         end else n_pass++;
         // Alternate fill-biased and drain-biased phases to hit full and empty.
         fill_phase     = ((cyc / 200) % 2) == 0;
         enable         = ($urandom_range(0, 7) != 0);
         read_ready     = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         write_ready    = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         readdata_left  = DW'($urandom);
         readdata_right = DW'($urandom);
         if (read) begin
            q.push_back({readdata_left, readdata_right});
            exp_left = readdata_left;
         end
         prev_read = read;
      end
      read_ready = 1'b0; write_ready = 1'b0; enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_round_robin();
      test_full_overrun();
      test_mute_underrun();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
